ram1_arbiter: RTL and testbench
===============================

RAM1_ARBITER -- requirements
Module: ram1_arbiter

Interface
REQ-001 The block SHALL have parameter WAIT_STATES, default 1, giving the number of cycles ram_en is held per access (legal 1..3).
REQ-002 The block SHALL have parameter ADDR_HI, default 2'b00, giving the upper two bits prepended to every 16-bit CPU address.
REQ-003 clk  input  1  single system clock; all state changes on its rising edge.
REQ-004 rst  input  1  synchronous, active-low reset.
REQ-005 if_req  input  1  instruction-fetch read request; held until if_ack.
REQ-006 if_addr  input  16  instruction-fetch word address.
REQ-007 if_rdata  output  16  fetched instruction word, valid while if_ack=1.
REQ-008 if_ack  output  1  one-cycle completion pulse for instruction fetch.
REQ-009 mem_req  input  1  data-memory request; held until mem_ack.
REQ-010 mem_we  input  1  1 = write, 0 = read; stable while mem_req=1.
REQ-011 mem_addr  input  16  data-memory word address.
REQ-012 mem_wdata  input  16  data-memory write word.
REQ-013 mem_rdata  output  16  data-memory read word, valid while mem_ack=1.
REQ-014 mem_ack  output  1  one-cycle completion pulse for data access.
REQ-015 stall  output  1  pipeline freeze; high while any request is pending and unacknowledged.
REQ-016 ram_addr  output  18  address to the downstream RAM1 controller.
REQ-017 ram_wdata  output  16  write data to the downstream RAM1 controller.
REQ-018 ram_we  output  1  1 = write access, 0 = read access.
REQ-019 ram_en  output  1  access strobe to the downstream RAM1 controller.
REQ-020 ram_rdata  input  16  read data returned by the RAM1 controller, valid in the last ram_en cycle.

Function
REQ-021 The FSM SHALL have states IDLE, SETUP, STROBE and ACK.
REQ-022 In IDLE with any request high, the FSM SHALL latch the winner and go to SETUP on the next edge.
REQ-023 On the same edge it SHALL register ram_addr = {ADDR_HI, addr}, ram_we and ram_wdata, where ram_we=0 and ram_wdata is unchanged for IF.
REQ-024 In SETUP, ram_en SHALL be 0; SETUP SHALL last exactly one cycle and then go to STROBE.
REQ-025 In STROBE, ram_en SHALL be 1 for exactly WAIT_STATES cycles, counted by a 2-bit down-counter.
REQ-026 ram_addr, ram_we and ram_wdata SHALL be stable from SETUP through the end of STROBE.
REQ-027 On the last STROBE edge, for reads, ram_rdata SHALL be captured into the winner's rdata register, and the FSM SHALL go to ACK.
REQ-028 In ACK, exactly the winner's ack SHALL be 1 for one cycle.
REQ-029 Latency: a request sampled at edge k SHALL produce its ack in the cycle following edge k+1+WAIT_STATES (3 cycles for the default).
REQ-030 When mem_req and if_req are both high in IDLE, mem SHALL win.
REQ-031 At the ACK edge, if the other requester (or a new mem_req) is pending, the FSM SHALL go directly to SETUP with the new winner, mem first; otherwise it SHALL go to IDLE.
REQ-032 A request dropped mid-access SHALL still complete and still pulse its ack.
REQ-033 if_rdata and mem_rdata SHALL hold their last captured value until the next capture for that port.
REQ-034 stall SHALL be combinational: (if_req & ~if_ack) | (mem_req & ~mem_ack).

Reset
REQ-035 While rst=0 at a clock edge, the FSM SHALL go to IDLE and the counter SHALL clear.
REQ-036 On that edge, ram_en, ram_we, if_ack and mem_ack SHALL go to 0; ram_addr, ram_wdata, if_rdata and mem_rdata SHALL go to 0.
REQ-037 Reset asserted mid-access SHALL abort the access, with no ack pulse and ram_en low from the next cycle.

Structure
REQ-038 A shared package SHALL hold the state encodings, RAM_AW=18, DW=16 and the default WAIT_STATES.
REQ-039 The block SHALL be a single module with the counter inline; no sub-module is required.

Verification
REQ-040 mem_req=1, mem_we=1, mem_addr=16'h0001, mem_wdata=16'h0004 -> ram_addr=18'h00001, ram_we=1, ram_wdata=16'h0004; ram_en high for 1 cycle; mem_ack on cycle 3; stall high for cycles 0-2.
REQ-041 if_req=1, if_addr=16'h0010, with ram_rdata=16'hABCD during strobe -> ram_we=0; if_rdata=16'hABCD with if_ack on cycle 3.
REQ-042 if_req and mem_req (read, 16'h0020) raised together -> mem_ack on cycle 3, if_ack on cycle 6, no IDLE cycle between the two accesses.
REQ-043 With WAIT_STATES=3, a single read -> ram_en high for 3 consecutive cycles and ack on cycle 5.
REQ-044 rst=0 asserted during STROBE -> ram_en=0 and no ack on the next cycle; after release, a fresh mem read completes normally.

Source files
------------

// File: rtl/ram1_arbiter_pkg.sv
// Shared definitions for the RAM1 arbiter: bus widths, default access length
// and the access-sequencer state encoding.
package ram1_arbiter_pkg;

    localparam int RAM_AW          = 18;
    localparam int DW              = 16;
    localparam int WAIT_STATES_DEF = 1;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETUP  = 2'd1,
        ST_STROBE = 2'd2,
        ST_ACK    = 2'd3
    } state_e;

endpackage

// File: rtl/ram1_arbiter.sv
// Two-port arbiter sharing one RAM1 controller between instruction fetch and
// data memory; data memory has priority, each access is SETUP, STROBE, ACK.
module ram1_arbiter
    import ram1_arbiter_pkg::*;
#(
    parameter int         WAIT_STATES = WAIT_STATES_DEF,
    parameter logic [1:0] ADDR_HI     = 2'b00
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req,
    input  logic [15:0]       if_addr,
    output logic [DW-1:0]     if_rdata,
    output logic              if_ack,
    input  logic              mem_req,
    input  logic              mem_we,
    input  logic [15:0]       mem_addr,
    input  logic [DW-1:0]     mem_wdata,
    output logic [DW-1:0]     mem_rdata,
    output logic              mem_ack,
    output logic              stall,
    output logic [RAM_AW-1:0] ram_addr,
    output logic [DW-1:0]     ram_wdata,
    output logic              ram_we,
    output logic              ram_en,
    input  logic [DW-1:0]     ram_rdata
);

    localparam logic [1:0] CNT_INIT = 2'(WAIT_STATES - 1);

    state_e              state_q;
    logic [1:0]          cnt_q;
    logic                win_mem_q;
    logic [RAM_AW-1:0]   ram_addr_q;
    logic [DW-1:0]       ram_wdata_q;
    logic                ram_we_q;
    logic                ram_en_q;
    logic                if_ack_q;
    logic                mem_ack_q;
    logic [DW-1:0]       if_rdata_q;
    logic [DW-1:0]       mem_rdata_q;

    logic                start_d;
    logic                start_mem_d;

    // At ACK the winner's request is still asserted, so only the other port may chain.
    always_comb begin
        start_d     = 1'b0;
        start_mem_d = 1'b0;
        case (state_q)
            ST_IDLE: begin
                start_d     = mem_req | if_req;
                start_mem_d = mem_req;
            end
            ST_ACK: begin
                if (win_mem_q) begin
                    start_d     = if_req;
                    start_mem_d = 1'b0;
                end else begin
                    start_d     = mem_req;
                    start_mem_d = mem_req;
                end
            end
            default: begin
                start_d     = 1'b0;
                start_mem_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= ST_IDLE;
            cnt_q       <= 2'd0;
            win_mem_q   <= 1'b0;
            ram_addr_q  <= '0;
            ram_wdata_q <= '0;
            ram_we_q    <= 1'b0;
            ram_en_q    <= 1'b0;
            if_ack_q    <= 1'b0;
            mem_ack_q   <= 1'b0;
            if_rdata_q  <= '0;
            mem_rdata_q <= '0;
        end else begin
            if_ack_q  <= 1'b0;
            mem_ack_q <= 1'b0;
            case (state_q)
                ST_IDLE, ST_ACK: begin
                    if (start_d) begin
                        win_mem_q <= start_mem_d;
                        if (start_mem_d) begin
                            ram_addr_q  <= {ADDR_HI, mem_addr};
                            ram_we_q    <= mem_we;
                            ram_wdata_q <= mem_wdata;
                        end else begin
                            ram_addr_q  <= {ADDR_HI, if_addr};
                            ram_we_q    <= 1'b0;
                        end
                        state_q <= ST_SETUP;
                    end else begin
                        state_q <= ST_IDLE;
                    end
                end
                ST_SETUP: begin
                    ram_en_q <= 1'b1;
                    cnt_q    <= CNT_INIT;
                    state_q  <= ST_STROBE;
                end
                ST_STROBE: begin
                    if (cnt_q == 2'd0) begin
                        ram_en_q <= 1'b0;
                        if (win_mem_q) begin
                            mem_ack_q <= 1'b1;
                            if (!ram_we_q) begin
                                mem_rdata_q <= ram_rdata;
                            end
                        end else begin
                            if_ack_q   <= 1'b1;
                            if_rdata_q <= ram_rdata;
                        end
                        state_q <= ST_ACK;
                    end else begin
                        cnt_q <= cnt_q - 2'd1;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign ram_addr  = ram_addr_q;
    assign ram_wdata = ram_wdata_q;
    assign ram_we    = ram_we_q;
    assign ram_en    = ram_en_q;
    assign if_ack    = if_ack_q;
    assign mem_ack   = mem_ack_q;
    assign if_rdata  = if_rdata_q;
    assign mem_rdata = mem_rdata_q;
    assign stall     = (if_req & ~if_ack_q) | (mem_req & ~mem_ack_q);

endmodule

// File: tb/tb_ram1_arbiter.sv
// Bench for ram1_arbiter: directed cases plus random single/dual transactions
// against an access-schedule and memory-content reference model.
module tb_ram1_arbiter;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        if_req = 1'b0;
    logic [15:0] if_addr = '0;
    logic        mem_req = 1'b0;
    logic        mem_we = 1'b0;
    logic [15:0] mem_addr = '0;
    logic [15:0] mem_wdata = '0;
    logic [15:0] ram_rdata = '0;
    logic        sel_b = 1'b0;

    logic [15:0] if_rdata_a, mem_rdata_a, ram_wdata_a, if_rdata_b, mem_rdata_b, ram_wdata_b;
    logic [17:0] ram_addr_a, ram_addr_b;
    logic        if_ack_a, mem_ack_a, stall_a, ram_we_a, ram_en_a;
    logic        if_ack_b, mem_ack_b, stall_b, ram_we_b, ram_en_b;

    int n_chk = 0;
    int n_err = 0;
    logic [15:0] last_mrd = '0;
    logic [15:0] last_ird = '0;
    logic [15:0] ram_store [logic [17:0]];
    logic [15:0] exp_mem   [logic [17:0]];

    always #5 clk = ~clk;

    ram1_arbiter dut_a (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata_a), .if_ack(if_ack_a),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata_a), .mem_ack(mem_ack_a), .stall(stall_a),
        .ram_addr(ram_addr_a), .ram_wdata(ram_wdata_a), .ram_we(ram_we_a), .ram_en(ram_en_a),
        .ram_rdata(ram_rdata)
    );

    ram1_arbiter #(.WAIT_STATES(3), .ADDR_HI(2'b10)) dut_b (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata_b), .if_ack(if_ack_b),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata_b), .mem_ack(mem_ack_b), .stall(stall_b),
        .ram_addr(ram_addr_b), .ram_wdata(ram_wdata_b), .ram_we(ram_we_b), .ram_en(ram_en_b),
        .ram_rdata(ram_rdata)
    );

    wire [15:0] o_if_rdata  = sel_b ? if_rdata_b  : if_rdata_a;
    wire [15:0] o_mem_rdata = sel_b ? mem_rdata_b : mem_rdata_a;
    wire [15:0] o_ram_wdata = sel_b ? ram_wdata_b : ram_wdata_a;
    wire [17:0] o_ram_addr  = sel_b ? ram_addr_b  : ram_addr_a;
    wire        o_if_ack    = sel_b ? if_ack_b    : if_ack_a;
    wire        o_mem_ack   = sel_b ? mem_ack_b   : mem_ack_a;
    wire        o_stall     = sel_b ? stall_b     : stall_a;
    wire        o_ram_we    = sel_b ? ram_we_b    : ram_we_a;
    wire        o_ram_en    = sel_b ? ram_en_b    : ram_en_a;

    function automatic logic [15:0] dflt(input logic [17:0] a);
        return ~a[15:0] ^ {6'h15, a[17:16], 8'h37};
    endfunction

    function automatic logic [15:0] ref_read(input logic [17:0] a);
        return exp_mem.exists(a) ? exp_mem[a] : dflt(a);
    endfunction

    function automatic logic [15:0] rnd_addr();
        return (($urandom_range(0, 1) != 0) ? 16'hF000 : 16'h0000) | 16'($urandom_range(0, 7));
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock: the emulated RAM1 controller writes and serves the selected arbiter.
    task automatic tick();
        @(negedge clk);
        if (o_ram_en && o_ram_we) ram_store[o_ram_addr] = o_ram_wdata;
        ram_rdata = ram_store.exists(o_ram_addr) ? ram_store[o_ram_addr] : dflt(o_ram_addr);
    endtask

    task automatic do_reset();
        tick();
        rst = 1'b0;
        mem_req = 1'b0;
        if_req = 1'b0;
        tick();
        tick();
        rst = 1'b1;
        last_mrd = '0;
        last_ird = '0;
    endtask

    // Schedule: each access is SETUP, WS strobe cycles, then ACK; a second access
    // starts its SETUP right after the first ACK cycle, mem always first.
    task automatic run_txn(input logic do_mem, input logic do_if, input logic mwe,
                           input logic [15:0] maddr, input logic [15:0] mwd,
                           input logic [15:0] iaddr);
        int ws, len, mem_base, if_base, mem_ack_c, if_ack_c, last;
        logic [1:0]  hi;
        logic [17:0] ma, ia;
        logic [15:0] exp_mrd, exp_ird;
        logic        in_m, in_i, en_exp;
        ws        = sel_b ? 3 : 1;
        hi        = sel_b ? 2'b10 : 2'b00;
        len       = ws + 2;
        mem_base  = 0;
        if_base   = do_mem ? len : 0;
        mem_ack_c = mem_base + len;
        if_ack_c  = if_base + len;
        last      = do_if ? if_ack_c : mem_ack_c;
        ma        = {hi, maddr};
        ia        = {hi, iaddr};
        exp_mrd   = last_mrd;
        exp_ird   = last_ird;
        if (do_mem && !mwe) exp_mrd = ref_read(ma);
        if (do_mem && mwe) exp_mem[ma] = mwd;
        if (do_if) exp_ird = ref_read(ia);
        for (int c = 0; c <= last + 2; c++) begin
            tick();
            if (c == 0) begin
                mem_req   = do_mem;
                mem_we    = mwe;
                mem_addr  = maddr;
                mem_wdata = mwd;
                if_req    = do_if;
                if_addr   = iaddr;
            end
            if (c == mem_ack_c + 1) mem_req = 1'b0;
            if (c == if_ack_c + 1) if_req = 1'b0;
            #1;
            in_m   = do_mem && c > mem_base && c < mem_ack_c;
            in_i   = do_if && c > if_base && c < if_ack_c;
            en_exp = (in_m && c > mem_base + 1) || (in_i && c > if_base + 1);
            chk("ram_en", o_ram_en, en_exp);
            if (in_m) begin
                chk("ram_addr_mem", o_ram_addr, ma);
                chk("ram_we_mem", o_ram_we, mwe);
                if (mwe) chk("ram_wdata", o_ram_wdata, mwd);
            end
            if (in_i) begin
                chk("ram_addr_if", o_ram_addr, ia);
                chk("ram_we_if", o_ram_we, 1'b0);
            end
            chk("mem_ack", o_mem_ack, do_mem && c == mem_ack_c);
            chk("if_ack", o_if_ack, do_if && c == if_ack_c);
            if (do_mem && !mwe && c == mem_ack_c) chk("mem_rdata", o_mem_rdata, exp_mrd);
            if (do_if && c == if_ack_c) chk("if_rdata", o_if_rdata, exp_ird);
            chk("stall", o_stall, c < last);
        end
        last_mrd = exp_mrd;
        last_ird = exp_ird;
        chk("mem_rdata_hold", o_mem_rdata, last_mrd);
        chk("if_rdata_hold", o_if_rdata, last_ird);
    endtask

    initial begin
        int kind, gap;
        do_reset();
        tick();
        #1;
        chk("rst_ram_en", o_ram_en, 1'b0);
        chk("rst_ram_we", o_ram_we, 1'b0);
        chk("rst_ram_addr", o_ram_addr, 18'h0);
        chk("rst_ram_wdata", o_ram_wdata, 16'h0);
        chk("rst_if_ack", o_if_ack, 1'b0);
        chk("rst_mem_ack", o_mem_ack, 1'b0);
        chk("rst_if_rdata", o_if_rdata, 16'h0);
        chk("rst_mem_rdata", o_mem_rdata, 16'h0);
        chk("rst_stall", o_stall, 1'b0);

        // Single write, single IF read of a known word, simultaneous requests.
        run_txn(1'b1, 1'b0, 1'b1, 16'h0001, 16'h0004, 16'h0000);
        ram_store[18'h00010] = 16'hABCD;
        exp_mem[18'h00010]   = 16'hABCD;
        run_txn(1'b0, 1'b1, 1'b0, 16'h0000, 16'h0000, 16'h0010);
        run_txn(1'b1, 1'b1, 1'b0, 16'h0020, 16'h0000, 16'h0010);

        // Reset during the strobe cycle aborts the access.
        tick();
        mem_req  = 1'b1;
        mem_we   = 1'b0;
        mem_addr = 16'h0020;
        tick();
        tick();
        #1;
        chk("abort_strobe_en", o_ram_en, 1'b1);
        rst = 1'b0;
        tick();
        #1;
        chk("abort_ram_en", o_ram_en, 1'b0);
        chk("abort_mem_ack", o_mem_ack, 1'b0);
        chk("abort_ram_addr", o_ram_addr, 18'h0);
        chk("abort_mem_rdata", o_mem_rdata, 16'h0);
        tick();
        rst = 1'b1;
        mem_req = 1'b0;
        #1;
        chk("abort_no_ack", o_mem_ack, 1'b0);
        last_mrd = '0;
        last_ird = '0;
        run_txn(1'b1, 1'b0, 1'b0, 16'h0020, 16'h0000, 16'h0000);

        for (int t = 0; t < 30; t++) begin
            kind = int'($urandom_range(0, 2));
            run_txn(kind != 1, kind != 0, 1'($urandom_range(0, 1)), rnd_addr(),
                    16'($urandom), rnd_addr());
            gap = int'($urandom_range(0, 2));
            repeat (gap) tick();
        end

        // Three wait states, upper address bits 2'b10.
        sel_b = 1'b1;
        do_reset();
        run_txn(1'b1, 1'b0, 1'b0, 16'h0123, 16'h0000, 16'h0000);
        run_txn(1'b1, 1'b1, 1'b1, 16'h0005, 16'h1234, 16'h0005);
        for (int t = 0; t < 15; t++) begin
            kind = int'($urandom_range(0, 2));
            run_txn(kind != 1, kind != 0, 1'($urandom_range(0, 1)), rnd_addr(),
                    16'($urandom), rnd_addr());
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
